jg3_code_gen: RTL and testbench
===============================

Name: jg3_code_gen

Overview:
- Inverse of the 3-bit JG3 classifier, which maps ABC to (X,Y) as follows: 000→01; 001..100→00; 101,110→10; 111→11.
- This block accepts a requested (X,Y) class and streams every 3-bit ABC code belonging to that class, in ascending order, over a valid/ready handshake.
- It sits on the stimulus side of the JG3 decoder. Its outputs drive decoder inputs in exhaustive-coverage and loopback benches.

Parameters:
- GAP_CYCLES, default 0: idle cycles inserted after each accepted code before scanning resumes (0..15).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous assert, active-high
- req_valid  input  1  request present
- req_x  input  1  target X
- req_y  input  1  target Y
- req_ready  output  1  block idle and able to accept a request
- out_valid  output  1  out_abc holds a member code
- out_abc  output  3  emitted code
- out_last  output  1  final code of the current class; qualified by out_valid
- out_ready  input  1  consumer accepts out_abc
- done  output  1  one-cycle pulse after the last code is accepted

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, cnt=0, gap counter=0, target=00. Outputs: req_ready=1, out_valid=0, out_abc=0, out_last=0, done=0.
- All outputs are decoded from registers only. There is no combinational input→output path.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch target={req_x,req_y}, cnt←0, go to SCAN.
- SCAN, each cycle:
  - req_ready=0. Evaluate class(cnt).
  - Non-member: out_valid=0, cnt←cnt+1.
  - Member: out_valid=1, out_abc=cnt, out_last=(cnt==LAST_CODE[target]).
  - out_abc, out_last and out_valid hold stable until out_ready=1. There is no retraction.
  - On handshake with out_last=1: go to DONE.
  - On handshake otherwise: cnt←cnt+1, then go to GAP if GAP_CYCLES>0, else stay in SCAN.
- GAP: out_valid=0 for exactly GAP_CYCLES cycles, then return to SCAN.
- DONE: done=1 for one cycle, then go to IDLE. req_ready returns to 1 in the following cycle.
- cnt never wraps. The last member code always exists at or before 7, so the scan terminates.
- Request latency with GAP_CYCLES=0, out_ready held at 1:
  - First code appears the cycle after acceptance plus (first member index) cycles.
  - Class 11 emits 111 at the 8th SCAN cycle.
- req_valid is ignored outside IDLE.
- out_ready is ignored when out_valid=0.
- rst asserted mid-stream aborts immediately to reset values. No done pulse is produced for the aborted request.

Optional Feature:
- Macro: JG3_GEN_COUNT_EN.
- Defined:
  - Adds output emit_cnt [2:0]: number of codes accepted in the current request.
  - Cleared on request acceptance, incremented on each handshake.
  - Valid alongside done and held until the next acceptance. Reset value 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package jg3_pkg holds:
  - localparam class codes CLS_00, CLS_01, CLS_10, CLS_11.
  - LAST_CODE table: 01→000, 00→100, 10→110, 11→111.
  - FSM state enum: IDLE, SCAN, GAP, DONE.
- One natural sub-module: jg3_class_of. It is the pure combinational abc[2:0]→{x,y} function, reused by the bench as its reference model.

Test Plan:
- Reset, then request {x,y}=01 with out_ready=1 → single code 000 with out_last=1, then done one cycle later. JG3_GEN_COUNT_EN: emit_cnt=1.
- Request 00, out_ready=1, GAP_CYCLES=0 → codes 001,010,011,100 on consecutive cycles, out_last only on 100, then done. emit_cnt=4.
- Request 10 with out_ready held low 3 cycles on 101 → out_abc stays 101, out_valid stays 1. Then 110 with out_last=1, then done.
- Request 11 → no out_valid for 7 SCAN cycles, then 111 with out_last=1. Feeding every emitted code through jg3_class_of returns 11.
- GAP_CYCLES=2, request 00 → exactly 2 out_valid=0 cycles between successive codes. req_valid pulsed mid-stream is ignored, and req_ready stays 0.
- Request 00, assert rst after 010 is accepted → all outputs at reset values immediately, no done pulse. The next request 01 works normally.

Source files
------------

// File: rtl/jg3_pkg.sv
// JG3 code generator shared definitions: class codes, last member
// per class and the generator FSM states.
package jg3_pkg;

    localparam logic [1:0] CLS_00 = 2'b00;
    localparam logic [1:0] CLS_01 = 2'b01;
    localparam logic [1:0] CLS_10 = 2'b10;
    localparam logic [1:0] CLS_11 = 2'b11;

    // Highest ABC code of each class, indexed by {x,y}
    localparam logic [2:0] LAST_CODE [4] = '{
        3'b100,
        3'b000,
        3'b110,
        3'b111
    };

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/jg3_class_of.sv
// JG3 classifier: maps a 3-bit ABC code to its {x,y} class.
module jg3_class_of
    import jg3_pkg::*;
(
    input  logic [2:0] abc,
    output logic [1:0] cls
);

    always_comb begin
        cls = CLS_00;
        unique case (1'b1)
            (abc == 3'd0):                 cls = CLS_01;
            (abc == 3'd5 || abc == 3'd6):  cls = CLS_10;
            (abc == 3'd7):                 cls = CLS_11;
            default:                       cls = CLS_00;
        endcase
    end

endmodule

// File: rtl/jg3_code_gen.sv
// JG3 code generator: streams all ABC codes of a requested class.
// Optional emit_cnt output enabled by JG3_GEN_COUNT_EN.
module jg3_code_gen
    import jg3_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_x,
    input  logic       req_y,
    output logic       req_ready,
    output logic       out_valid,
    output logic [2:0] out_abc,
    output logic       out_last,
    input  logic       out_ready,
    output logic       done
`ifdef JG3_GEN_COUNT_EN
    ,
    output logic [2:0] emit_cnt
`endif
);

    localparam logic [3:0] GAP_LAST =
        (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [3:0] gap, gap_n;
    logic [1:0] target, target_n;
    logic [1:0] cls;
    logic       member;
    logic       is_last;
    logic       hs;

    jg3_class_of u_cls (
        .abc (cnt),
        .cls (cls)
    );

    assign member  = (state == SCAN) && (cls == target);
    assign is_last = (cnt == LAST_CODE[target]);
    assign hs      = member && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            gap    <= 4'd0;
            target <= CLS_00;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            gap    <= gap_n;
            target <= target_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        gap_n    = gap;
        target_n = target;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    target_n = {req_x, req_y};
                    cnt_n    = 3'd0;
                    state_n  = SCAN;
                end
            end
            SCAN: begin
                if (!member) begin
                    cnt_n = cnt + 3'd1;
                end else if (out_ready) begin
                    if (is_last) begin
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt + 3'd1;
                        if (GAP_CYCLES > 0) begin
                            state_n = GAP;
                            gap_n   = 4'd0;
                        end
                    end
                end
            end
            GAP: begin
                if (gap == GAP_LAST) state_n = SCAN;
                else                 gap_n   = gap + 4'd1;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign out_valid = member;
    assign out_abc   = member ? cnt : 3'd0;
    assign out_last  = member && is_last;
    assign done      = (state == DONE);

`ifdef JG3_GEN_COUNT_EN
    // Holds its value after done until the next request is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            emit_cnt <= 3'd0;
        end else if (req_ready && req_valid) begin
            emit_cnt <= 3'd0;
        end else if (hs) begin
            emit_cnt <= emit_cnt + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jg3_code_gen.sv
// Bench for jg3_code_gen: two instances (GAP_CYCLES 0 and 2) checked
// cycle by cycle against an arithmetic schedule of expected codes.
module tb_jg3_code_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid [2];
    logic       req_x     [2];
    logic       req_y     [2];
    logic       out_ready [2];
    logic       req_ready [2];
    logic       out_valid [2];
    logic       out_last  [2];
    logic       done      [2];
    logic [2:0] out_abc   [2];
`ifdef JG3_GEN_COUNT_EN
    logic [2:0] emit_cnt  [2];
`endif
    logic [2:0] cabc;
    logic [1:0] ccls;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jg3_code_gen #(.GAP_CYCLES(0)) u_g0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[0]),
        .req_x     (req_x[0]),
        .req_y     (req_y[0]),
        .req_ready (req_ready[0]),
        .out_valid (out_valid[0]),
        .out_abc   (out_abc[0]),
        .out_last  (out_last[0]),
        .out_ready (out_ready[0]),
        .done      (done[0])
`ifdef JG3_GEN_COUNT_EN
        ,
        .emit_cnt  (emit_cnt[0])
`endif
    );

    jg3_code_gen #(.GAP_CYCLES(2)) u_g2 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[1]),
        .req_x     (req_x[1]),
        .req_y     (req_y[1]),
        .req_ready (req_ready[1]),
        .out_valid (out_valid[1]),
        .out_abc   (out_abc[1]),
        .out_last  (out_last[1]),
        .out_ready (out_ready[1]),
        .done      (done[1])
`ifdef JG3_GEN_COUNT_EN
        ,
        .emit_cnt  (emit_cnt[1])
`endif
    );

    jg3_class_of u_cls (
        .abc (cabc),
        .cls (ccls)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_cls(int abc);
        if (abc == 0) return 1;
        if (abc <= 4) return 0;
        if (abc <= 6) return 2;
        return 3;
    endfunction

    task automatic chk_reset_vals(int g);
        chk("rst_ready", req_ready[g], 1);
        chk("rst_valid", out_valid[g], 0);
        chk("rst_abc", out_abc[g], 0);
        chk("rst_last", out_last[g], 0);
        chk("rst_done", done[g], 0);
`ifdef JG3_GEN_COUNT_EN
        chk("rst_emit", emit_cnt[g], 0);
`endif
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 3 cycles first
    task automatic run_req(int g, int tgt, int mode, int abort_n);
        int codes[$];
        int idx, valid_at, hs_n, stall, gap, k;
        bit fin, done_pend, ab;
        logic [1:0] t2;
        gap = (g == 1) ? 2 : 0;
        for (int c = 0; c < 8; c++)
            if (ref_cls(c) == tgt) codes.push_back(c);
        t2 = 2'(tgt);
        @(negedge clk);
        chk("idle_ready", req_ready[g], 1);
        chk("idle_valid", out_valid[g], 0);
        req_valid[g] = 1'b1;
        req_x[g] = t2[1];
        req_y[g] = t2[0];
        out_ready[g] = 1'b0;
        idx = 0;
        valid_at = 1 + codes[0];
        hs_n = 0;
        stall = (mode == 2) ? 3 : 0;
        fin = 0;
        done_pend = 0;
        ab = 0;
        for (k = 1; k < 64 && !fin; k++) begin
            @(negedge clk);
            if (done_pend) begin
                req_valid[g] = 1'b0;
                chk("done_pulse", done[g], 1);
                chk("done_ready", req_ready[g], 0);
                chk("done_valid", out_valid[g], 0);
`ifdef JG3_GEN_COUNT_EN
                chk("emit_cnt", emit_cnt[g], codes.size());
`endif
                @(negedge clk);
                chk("done_clear", done[g], 0);
                chk("ready_back", req_ready[g], 1);
                fin = 1;
            end else begin
                req_valid[g] = ($urandom_range(0, 3) == 0);
                req_x[g] = 1'($urandom_range(0, 1));
                req_y[g] = 1'($urandom_range(0, 1));
                chk("busy_ready", req_ready[g], 0);
                chk("no_done", done[g], 0);
                if (k < valid_at) begin
                    chk("idle_gap", out_valid[g], 0);
                    out_ready[g] = 1'($urandom_range(0, 1));
                end else begin
                    chk("valid", out_valid[g], 1);
                    chk("abc", out_abc[g], codes[idx]);
                    chk("last", out_last[g],
                        (idx == codes.size() - 1) ? 1 : 0);
                    if (stall > 0) begin
                        out_ready[g] = 1'b0;
                        stall--;
                    end else if (mode == 1) begin
                        out_ready[g] = 1'($urandom_range(0, 1));
                    end else begin
                        out_ready[g] = 1'b1;
                    end
                    if (out_ready[g]) begin
                        hs_n++;
                        if (idx == codes.size() - 1) begin
                            done_pend = 1;
                        end else begin
                            idx++;
                            valid_at = k + gap + codes[idx]
                                     - codes[idx-1];
                        end
                        ab = (hs_n == abort_n);
                    end
                end
                if (ab) begin
                    @(posedge clk);
                    #2;
                    rst = 1'b1;
                    req_valid[g] = 1'b0;
                    #1;
                    chk_reset_vals(g);
                    @(negedge clk);
                    rst = 1'b0;
                    repeat (2) begin
                        @(negedge clk);
                        chk("abort_no_done", done[g], 0);
                        chk("abort_ready", req_ready[g], 1);
                    end
                    fin = 1;
                end
            end
        end
        req_valid[g] = 1'b0;
        out_ready[g] = 1'b0;
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0;
            req_x[g] = 1'b0;
            req_y[g] = 1'b0;
            out_ready[g] = 1'b0;
        end
        cabc = 3'd0;
        #3;
        chk_reset_vals(0);
        chk_reset_vals(1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals(0);

        for (int c = 0; c < 8; c++) begin
            cabc = 3'(c);
            #1;
            chk("class_of", ccls, ref_cls(c));
        end

        run_req(0, 1, 0, 0);
        run_req(0, 0, 0, 0);
        run_req(0, 2, 2, 0);
        run_req(0, 3, 0, 0);
        run_req(1, 0, 0, 0);
        run_req(1, 2, 0, 0);
        run_req(0, 0, 0, 2);
        run_req(0, 1, 0, 0);
        run_req(1, 0, 1, 3);
        run_req(1, 3, 0, 0);

        for (int i = 0; i < 16; i++)
            run_req(0, $urandom_range(0, 3), 1, 0);
        for (int i = 0; i < 8; i++)
            run_req(1, $urandom_range(0, 3), 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
